// File: rtl/ahb5_req_manager.sv
// Valid/ready request channel to pipelined AHB5 manager SINGLE transfers, one response per request.
// Optional exclusive-access support is enabled by defining AHB5_REQ_MANAGER_EXCL_EN.
module ahb5_req_manager #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned HMASTER_WIDTH = 8,
  parameter logic [HMASTER_WIDTH-1:0] HMASTER_ID = '0,
  parameter logic [3:0] HPROT  = 4'h3,
  parameter logic       NONSEC = 1'b1
) (
  input  logic                       hclk,
  input  logic                       hreset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  input  logic [2:0]                 req_size,
  input  logic [DATA_WIDTH-1:0]      req_wdata,
  input  logic [DATA_WIDTH/8-1:0]    req_wstrb,
  input  logic                       req_excl,
  output logic                       rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       rsp_err,
  output logic                       rsp_exokay,
  output logic [ADDR_WIDTH-1:0]      haddr,
  output logic [1:0]                 htrans,
  output logic                       hwrite,
  output logic [2:0]                 hsize,
  output logic [2:0]                 hburst,
  output logic                       hmastlock,
  output logic [3:0]                 hprot,
  output logic                       hnonsec,
  output logic                       hexcl,
  output logic [HMASTER_WIDTH-1:0]   hmaster,
  output logic [DATA_WIDTH-1:0]      hwdata,
  output logic [DATA_WIDTH/8-1:0]    hwstrb,
  input  logic [DATA_WIDTH-1:0]      hrdata,
  input  logic                       hready,
  input  logic                       hresp,
  input  logic                       hexokay
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Address-phase register
  logic                  ap_v_q, ap_v_d;
  logic [ADDR_WIDTH-1:0] ap_addr_q, ap_addr_d;
  logic                  ap_write_q, ap_write_d;
  logic [2:0]            ap_size_q, ap_size_d;
  logic [DATA_WIDTH-1:0] ap_wdata_q, ap_wdata_d;
  logic [STRB_WIDTH-1:0] ap_wstrb_q, ap_wstrb_d;

  // Data-phase register
  logic                  dp_v_q, dp_v_d;
  logic                  dp_write_q, dp_write_d;
  logic [DATA_WIDTH-1:0] dp_wdata_q, dp_wdata_d;
  logic [STRB_WIDTH-1:0] dp_wstrb_q, dp_wstrb_d;

  // Response register
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_exokay_q, rsp_exokay_d;

  logic accept;
  logic complete;

  assign req_ready = !hreset && (!ap_v_q || hready);
  assign accept    = req_valid && req_ready;
  assign complete  = dp_v_q && hready;

`ifdef AHB5_REQ_MANAGER_EXCL_EN
  logic ap_excl_q, ap_excl_d;
  logic dp_excl_q, dp_excl_d;

  always_comb begin
    ap_excl_d    = ap_excl_q;
    dp_excl_d    = dp_excl_q;
    rsp_exokay_d = 1'b0;
    if (accept) ap_excl_d = req_excl;
    if (ap_v_q && hready) dp_excl_d = ap_excl_q;
    if (complete) rsp_exokay_d = dp_excl_q && hexokay && !hresp;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      ap_excl_q <= 1'b0;
      dp_excl_q <= 1'b0;
    end else begin
      ap_excl_q <= ap_excl_d;
      dp_excl_q <= dp_excl_d;
    end
  end

  assign hexcl = ap_v_q && ap_excl_q;
`else
  logic unused_excl;
  assign unused_excl  = req_excl ^ hexokay;
  assign rsp_exokay_d = 1'b0;
  assign hexcl        = 1'b0;
`endif

  // Pipeline advance: accept into AP, AP into DP, DP completion into response
  always_comb begin
    ap_v_d      = ap_v_q;
    ap_addr_d   = ap_addr_q;
    ap_write_d  = ap_write_q;
    ap_size_d   = ap_size_q;
    ap_wdata_d  = ap_wdata_q;
    ap_wstrb_d  = ap_wstrb_q;
    dp_v_d      = dp_v_q;
    dp_write_d  = dp_write_q;
    dp_wdata_d  = dp_wdata_q;
    dp_wstrb_d  = dp_wstrb_q;
    rsp_valid_d = complete;
    rsp_err_d   = complete && hresp;
    rsp_rdata_d = '0;

    if (accept) begin
      ap_v_d     = 1'b1;
      ap_addr_d  = req_addr;
      ap_write_d = req_write;
      ap_size_d  = req_size;
      ap_wdata_d = req_wdata;
      ap_wstrb_d = req_wstrb;
    end else if (hready) begin
      ap_v_d = 1'b0;
    end

    if (ap_v_q && hready) begin
      dp_v_d     = 1'b1;
      dp_write_d = ap_write_q;
      dp_wdata_d = ap_wdata_q;
      dp_wstrb_d = ap_wstrb_q;
    end else if (dp_v_q && hready) begin
      dp_v_d = 1'b0;
    end

    if (complete && !dp_write_q) rsp_rdata_d = hrdata;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      ap_v_q       <= 1'b0;
      ap_addr_q    <= '0;
      ap_write_q   <= 1'b0;
      ap_size_q    <= '0;
      ap_wdata_q   <= '0;
      ap_wstrb_q   <= '0;
      dp_v_q       <= 1'b0;
      dp_write_q   <= 1'b0;
      dp_wdata_q   <= '0;
      dp_wstrb_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp_exokay_q <= 1'b0;
    end else begin
      ap_v_q       <= ap_v_d;
      ap_addr_q    <= ap_addr_d;
      ap_write_q   <= ap_write_d;
      ap_size_q    <= ap_size_d;
      ap_wdata_q   <= ap_wdata_d;
      ap_wstrb_q   <= ap_wstrb_d;
      dp_v_q       <= dp_v_d;
      dp_write_q   <= dp_write_d;
      dp_wdata_q   <= dp_wdata_d;
      dp_wstrb_q   <= dp_wstrb_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      rsp_exokay_q <= rsp_exokay_d;
    end
  end

  // Address-phase outputs are zeroed while IDLE; they only change on hready
  assign htrans    = ap_v_q ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr     = ap_v_q ? ap_addr_q : '0;
  assign hwrite    = ap_v_q && ap_write_q;
  assign hsize     = ap_v_q ? ap_size_q : 3'b000;
  assign hwdata    = (dp_v_q && dp_write_q) ? dp_wdata_q : '0;
  assign hwstrb    = (dp_v_q && dp_write_q) ? dp_wstrb_q : '0;
  assign hburst    = HBURST_SINGLE;
  assign hmastlock = 1'b0;
  assign hprot     = HPROT;
  assign hnonsec   = NONSEC;
  assign hmaster   = HMASTER_ID;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_exokay = rsp_exokay_q;

endmodule

// File: doc/ahb5_req_manager.md
# ahb5_req_manager

Converts a simple valid/ready request channel into pipelined AHB5 manager transfers and returns one response per request. Sits directly upstream of the AHB5 interface, driving its MANAGER modport from CPU/DMA-style request logic. Issues SINGLE transfers only, with up to one address phase and one data phase in flight. Supports back-to-back throughput of one transfer per cycle when there are no wait states.

## Interface
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; a multiple of 8. STRB_WIDTH = DATA_WIDTH/8.
- HMASTER_WIDTH, 8, width of hmaster.
- HMASTER_ID, 0, constant value driven on hmaster.
- HPROT, 4'h3, constant value driven on hprot (memory_type_t).
- NONSEC, 1'b1, constant value driven on hnonsec.

Clocking and reset (already decided): one clock, hclk; reset hreset is synchronous and active-high.

Ports:
- hclk  in  1  clock.
- hreset  in  1  synchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  3  hsize encoding.
- req_wdata  in  DATA_WIDTH  write data.
- req_wstrb  in  STRB_WIDTH  write strobes.
- req_excl  in  1  exclusive request (used only when the macro is defined).
- rsp_valid  out  1  single-cycle response pulse; no backpressure.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  transfer ended with ERROR.
- rsp_exokay  out  1  exclusive succeeded.
- haddr  out  ADDR_WIDTH  AHB address.
- htrans  out  2  IDLE/NONSEQ only.
- hwrite  out  1  AHB write.
- hsize  out  3  AHB size.
- hburst  out  3  constant SINGLE.
- hmastlock  out  1  constant 0.
- hprot  out  4  HPROT.
- hnonsec  out  1  NONSEC.
- hexcl  out  1  exclusive.
- hmaster  out  HMASTER_WIDTH  HMASTER_ID.
- hwdata  out  DATA_WIDTH  write data.
- hwstrb  out  STRB_WIDTH  write strobes.
- hrdata  in  DATA_WIDTH  read data.
- hready  in  1  transfer-complete / bus ready.
- hresp  in  1  0 = OKAY, 1 = ERROR.
- hexokay  in  1  exclusive okay.

## Operation
- **Address-phase register (AP):** holds addr, write, size, wdata, wstrb and excl, plus valid bit ap_v.
  - htrans = NONSEQ when ap_v, else IDLE.
- **Data-phase register (DP):** holds write, wdata, wstrb and excl, plus valid bit dp_v.
  - hwdata/hwstrb come from DP when dp_v && write, else 0.
- **req_ready** = !ap_v || hready. It is combinational from hready and is 0 during reset.
- **Accept** (req_valid && req_ready): load AP and set ap_v = 1. Otherwise, if hready, clear ap_v.
- **AP to DP:** when ap_v && hready, copy AP to DP and set dp_v = 1. Otherwise, if dp_v && hready, clear dp_v.
- **Address stability:** all AP outputs hold stable while hready = 0.
- **Completion:** dp_v && hready. In the next cycle:
  - rsp_valid = 1.
  - rsp_err = hresp.
  - rsp_rdata = read ? hrdata : 0.
  - rsp_exokay = excl && hexokay && !hresp.
- **ERROR response:** the first cycle (hresp = 1, hready = 0) is a wait state. A pending AP is not cancelled; it is issued normally after the error.
- **Response order:** responses are returned strictly in request order.
- **Upstream responsibility:** req_addr alignment versus req_size, and req_size ≤ log2(STRB_WIDTH). These values pass through unchecked.

## Timing
- **Reset values:** ap_v = dp_v = 0. htrans = IDLE; haddr, hwrite, hsize, hwdata, hwstrb, hexcl = 0; rsp_valid, rsp_rdata, rsp_err, rsp_exokay = 0; req_ready = 0. Constant outputs hold their parameter values.
- **Latency:** request accepted in cycle 0, NONSEQ in cycle 1, data phase in cycle 2 (hready = 1), rsp_valid in cycle 3. Each wait state adds one cycle.
- **Throughput:** with hready held at 1, a new request is accepted every cycle and one response is produced per cycle.
- **Simultaneous events:** acceptance, AP-to-DP, and completion may all occur in the same cycle.
- **Reset mid-transfer:** in-flight transfers are dropped and no response is produced. The bus returns to IDLE in the cycle after hreset is sampled.

## Configuration
- **AHB5_REQ_MANAGER_EXCL_EN defined:** req_excl is captured and driven on hexcl during the address phase; rsp_exokay reports the result as described above.
- **Not defined:** req_excl is ignored, hexcl = 0, rsp_exokay = 0, and the excl bits are not stored.

## Test plan
- **Single read:** read request at addr 0x100, size 2, hready = 1, hrdata = 0xDEADBEEF → NONSEQ in cycle 1, rsp_valid in cycle 3 with rdata 0xDEADBEEF and err 0.
- **Back-to-back writes:** writes to 0x0, 0x4, 0x8 in consecutive cycles with hready = 1 → NONSEQ on 3 consecutive cycles; hwdata lags haddr by 1 cycle; 3 consecutive responses with err 0.
- **Wait states:** hready = 0 for 2 cycles during a read data phase with a second request pending → haddr/htrans held stable, req_ready = 0, response delayed by 2 cycles.
- **ERROR:** two-cycle ERROR on a write to 0x200 → rsp_err = 1 and rdata 0; the following pending read completes normally with err 0.
- **Exclusive (macro defined):** excl read with hexokay = 1 → hexcl = 1 in the address phase and rsp_exokay = 1. With the macro undefined → hexcl = 0 and rsp_exokay = 0.
- **Reset mid-transfer:** hreset asserted during a data phase → no rsp_valid; htrans = IDLE and req_ready = 0 the next cycle.
